// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle control FSM for the single-ALU processor datapath.
//            Fetches one instruction, decodes its opcode class and sequences
//            the shared ALU, data memory and register-file write-back.
//            Memory waits are guarded by a watchdog that aborts with bus_err.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset (also gates all outputs)
//   run          in   permits a new fetch; sampled only in FETCH
//   opcode[6:0]  in   IR[6:0], valid from DECODE onward
//   branch_taken in   ALU compare result, used in EXECUTE of a branch
//   imem_ready   in   instruction memory data valid
//   dmem_ready   in   data memory access complete
//   imem_req     out  instruction fetch request
//   ir_we        out  IR load strobe
//   pc_we        out  PC write enable
//   pc_sel       out  0 = PC+4, 1 = branch target
//   MUXsel1      out  ALU operand-B select, 0 = R2D2, 1 = imm
//   aluout_we    out  ALU result register load
//   dmem_req     out  data memory request
//   dmem_we      out  1 = store, 0 = load
//   reg_we       out  register file write enable
//   wb_sel       out  0 = ALU result, 1 = load data
//   illegal_op   out  one-cycle pulse on an unknown opcode
//   bus_err      out  one-cycle pulse on a memory wait timeout
//   busy         out  low only in FETCH with run = 0
// ============================================================================
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       MUXsel1,
  output logic       aluout_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       illegal_op,
  output logic       bus_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  // OP_NONE doubles as the reset value and the "illegal" class.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_R    = 3'd1,
    OP_I    = 3'd2,
    OP_LD   = 3'd3,
    OP_ST   = 3'd4,
    OP_BR   = 3'd5
  } op_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  op_t        op_class;

  function automatic op_t classify(input logic [6:0] opc);
    case (opc)
      7'b0110011: classify = OP_R;
      7'b0010011: classify = OP_I;
      7'b0000011: classify = OP_LD;
      7'b0100011: classify = OP_ST;
      7'b1100011: classify = OP_BR;
      default:    classify = OP_NONE;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    op_class   = classify(opcode);
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    MUXsel1    = 1'b0;
    aluout_we  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    busy       = 1'b1;

    case (state_q)
      S_FETCH: begin
        imem_req = run;
        busy     = run;
        if (run) begin
          // A ready arriving on the timeout cycle still completes the fetch.
          if (imem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end else if (cnt_q == TIMEOUT_CNT) begin
            bus_err = 1'b1;
            cnt_d   = 8'd0;  // re-entering FETCH restarts the watchdog
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_DECODE: begin
        op_d = op_class;
        // op_q is not yet updated here, so the pulse comes from the live opcode.
        if (op_class == OP_NONE) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
          cnt_d      = 8'd0;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        case (op_q)
          OP_R: begin
            aluout_we = 1'b1;
            state_d   = S_WB;
          end
          OP_I: begin
            MUXsel1   = 1'b1;
            aluout_we = 1'b1;
            state_d   = S_WB;
          end
          OP_LD, OP_ST: begin
            MUXsel1   = 1'b1;
            aluout_we = 1'b1;
            state_d   = S_MEM;
            cnt_d     = 8'd0;
          end
          OP_BR: begin
            pc_sel  = 1'b1;
            pc_we   = branch_taken;
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end
          default: begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_ST);
        if (dmem_ready) begin
          if (op_q == OP_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (op_q == OP_LD);
        state_d = S_FETCH;
        cnt_d   = 8'd0;
      end

      default: begin
        state_d = S_FETCH;
        cnt_d   = 8'd0;
      end
    endcase

    // Outputs are squashed combinationally so nothing leaks during reset.
    if (!rst_n) begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      MUXsel1    = 1'b0;
      aluout_we  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= OP_NONE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Cycle-by-cycle vector bench for multicycle_ctrl. Directed rows
//            cover the documented scenarios; random instructions are expanded
//            into per-cycle expectations from the instruction-level rules
//            (phase lengths from ready delays, class-based strobes).
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  // Output vector bit masks, MSB first: imem_req .. busy
  localparam logic [12:0] E_IMEM  = 13'h1000;
  localparam logic [12:0] E_IRWE  = 13'h0800;
  localparam logic [12:0] E_PCWE  = 13'h0400;
  localparam logic [12:0] E_PCSEL = 13'h0200;
  localparam logic [12:0] E_MUX   = 13'h0100;
  localparam logic [12:0] E_ALU   = 13'h0080;
  localparam logic [12:0] E_DREQ  = 13'h0040;
  localparam logic [12:0] E_DWE   = 13'h0020;
  localparam logic [12:0] E_REGWE = 13'h0010;
  localparam logic [12:0] E_WBSEL = 13'h0008;
  localparam logic [12:0] E_ILL   = 13'h0004;
  localparam logic [12:0] E_BERR  = 13'h0002;
  localparam logic [12:0] E_BUSY  = 13'h0001;
  localparam logic [12:0] E_FDONE = E_IMEM | E_IRWE | E_PCWE | E_BUSY;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic [6:0]  opc;
    logic        bt;
    logic        ir;
    logic        dr;
    logic [12:0] exp;
    int          tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic imem_req, ir_we, pc_we, pc_sel, MUXsel1, aluout_we, dmem_req;
  logic dmem_we, reg_we, wb_sel, illegal_op, bus_err, busy;
  logic [12:0] outs;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .MUXsel1(MUXsel1),
    .aluout_we(aluout_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .wb_sel(wb_sel), .illegal_op(illegal_op),
    .bus_err(bus_err), .busy(busy)
  );

  assign outs = {imem_req, ir_we, pc_we, pc_sel, MUXsel1, aluout_we,
                 dmem_req, dmem_we, reg_we, wb_sel, illegal_op, bus_err, busy};

  function automatic vec_t mk(logic rn, logic rr, logic [6:0] op, logic bt,
                              logic ir, logic dr, logic [12:0] e, int tag);
    vec_t v;
    v.rst_n = rn; v.run = rr; v.opc = op; v.bt = bt;
    v.ir = ir; v.dr = dr; v.exp = e; v.tag = tag;
    return v;
  endfunction

  task automatic add(logic rn, logic rr, logic [6:0] op, logic bt,
                     logic ir, logic dr, logic [12:0] e, int tag);
    vq.push_back(mk(rn, rr, op, bt, ir, dr, e, tag));
  endtask

  // Random instruction expanded into cycles from the instruction-level rules:
  // fetch lasts min(delay, timeout) wait cycles plus one, decode one cycle,
  // execute one, memory phase like fetch, write-back one.
  task automatic gen_random(int tag);
    vec_t t[$];
    int cls, di, dd, idle;
    logic [6:0] opc;
    logic bt;
    logic aborted;
    cls = $urandom_range(0, 5);
    case (cls)
      1: opc = OPC_R;
      2: opc = OPC_I;
      3: opc = OPC_LD;
      4: opc = OPC_ST;
      5: opc = OPC_BR;
      default: begin
        opc = 7'($urandom);
        while (opc == OPC_R || opc == OPC_I || opc == OPC_LD ||
               opc == OPC_ST || opc == OPC_BR)
          opc = 7'($urandom);
      end
    endcase
    di = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 3);
    dd = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 3);
    bt = 1'($urandom);
    idle = $urandom_range(0, 2);
    aborted = 1'b0;
    for (int k = 0; k < idle; k++)
      t.push_back(mk(1, 0, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 13'h0, tag));
    // fetch phase
    for (int k = 0; k <= TMO; k++) begin
      if (k == di) begin
        t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 1, 1'($urandom), E_FDONE, tag));
        break;
      end else if (k == TMO) begin
        t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 0, 1'($urandom),
                       E_IMEM | E_BERR | E_BUSY, tag));
        aborted = 1'b1;
      end else begin
        t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 0, 1'($urandom), E_IMEM | E_BUSY, tag));
      end
    end
    if (!aborted) begin
      t.push_back(mk(1, 1, opc, 1'($urandom), 1'($urandom), 1'($urandom),
                     (cls == 0) ? (E_ILL | E_BUSY) : E_BUSY, tag));
      if (cls != 0) begin
        logic [12:0] ex;
        case (cls)
          1:       ex = E_ALU | E_BUSY;
          2, 3, 4: ex = E_MUX | E_ALU | E_BUSY;
          default: ex = E_PCSEL | (bt ? E_PCWE : 13'h0) | E_BUSY;
        endcase
        t.push_back(mk(1, 1, 7'($urandom), bt, 1'($urandom), 1'($urandom), ex, tag));
        if (cls == 3 || cls == 4) begin
          logic [12:0] me;
          me = E_DREQ | E_BUSY | ((cls == 4) ? E_DWE : 13'h0);
          for (int k = 0; k <= TMO; k++) begin
            if (k == dd) begin
              t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 1'($urandom), 1, me, tag));
              break;
            end else if (k == TMO) begin
              t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 1'($urandom), 0, me | E_BERR, tag));
              aborted = 1'b1;
            end else begin
              t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 1'($urandom), 0, me, tag));
            end
          end
        end
        if (!aborted && (cls == 1 || cls == 2 || cls == 3))
          t.push_back(mk(1, 1, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         E_REGWE | E_BUSY | ((cls == 3) ? E_WBSEL : 13'h0), tag));
      end
    end
    // Occasionally cut the instruction short with a reset cycle.
    if ($urandom_range(0, 9) == 0) begin
      int cut;
      cut = $urandom_range(0, t.size() - 1);
      t[cut] = mk(0, 1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 13'h0, tag);
      while (t.size() > cut + 1) void'(t.pop_back());
    end
    foreach (t[i]) vq.push_back(t[i]);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n        = v.rst_n;
    run          = v.run;
    opcode       = v.opc;
    branch_taken = v.bt;
    imem_ready   = v.ir;
    dmem_ready   = v.dr;
    #1;
    checks++;
    if (outs !== v.exp) begin
      errors++;
      $display("FAIL sec%0d row%0d outputs=%b expected=%b", v.tag, idx, outs, v.exp);
    end
  endtask

  initial begin
    // 1: reset forces every output low, even with run/ready high
    add(0, 1, 7'd0, 1, 1, 1, 13'h0, 1);
    add(0, 1, OPC_R, 1, 1, 1, 13'h0, 1);
    add(1, 0, 7'd0, 0, 1, 1, 13'h0, 1);

    // 2: R-type, ready in first fetch cycle
    add(1, 1, 7'd0, 0, 1, 0, E_FDONE, 2);
    add(1, 1, OPC_R, 0, 0, 0, E_BUSY, 2);
    add(1, 1, 7'd0, 0, 0, 1, E_ALU | E_BUSY, 2);
    add(1, 1, 7'd0, 0, 0, 1, E_REGWE | E_BUSY, 2);
    add(1, 0, 7'd0, 0, 0, 0, 13'h0, 2);

    // 3/4: branch taken then not taken
    for (int b = 1; b >= 0; b--) begin
      add(1, 1, 7'd0, 0, 1, 0, E_FDONE, 4 - b);
      add(1, 1, OPC_BR, 0, 0, 0, E_BUSY, 4 - b);
      add(1, 1, 7'd0, 1'(b), 0, 0, E_PCSEL | E_BUSY | ((b == 1) ? E_PCWE : 13'h0), 4 - b);
      add(1, 0, 7'd0, 0, 0, 0, 13'h0, 4 - b);
    end

    // 5: illegal opcode
    add(1, 1, 7'd0, 0, 1, 1, E_FDONE, 5);
    add(1, 1, 7'h7F, 0, 0, 1, E_ILL | E_BUSY, 5);
    add(1, 0, 7'h7F, 0, 0, 1, 13'h0, 5);

    // 6: load with three low-ready memory cycles, 8 cycles total
    add(1, 1, 7'd0, 0, 1, 1, E_FDONE, 6);
    add(1, 1, OPC_LD, 0, 0, 1, E_BUSY, 6);
    add(1, 1, 7'd0, 0, 0, 1, E_MUX | E_ALU | E_BUSY, 6);
    for (int k = 0; k < 3; k++) add(1, 1, 7'd0, 0, 0, 0, E_DREQ | E_BUSY, 6);
    add(1, 1, 7'd0, 0, 0, 1, E_DREQ | E_BUSY, 6);
    add(1, 1, 7'd0, 0, 0, 1, E_REGWE | E_WBSEL | E_BUSY, 6);
    add(1, 0, 7'd0, 0, 0, 0, 13'h0, 6);

    // 7: store timeout (bus_err in 16th MEM cycle); 8: ready on 16th cycle wins
    for (int s = 7; s <= 8; s++) begin
      add(1, 1, 7'd0, 0, 1, 0, E_FDONE, s);
      add(1, 1, OPC_ST, 0, 0, 0, E_BUSY, s);
      add(1, 1, 7'd0, 0, 0, 0, E_MUX | E_ALU | E_BUSY, s);
      for (int k = 1; k <= 15; k++) add(1, 1, 7'd0, 0, 0, 0, E_DREQ | E_DWE | E_BUSY, s);
      add(1, 1, 7'd0, 0, 0, (s == 8) ? 1'b1 : 1'b0,
          E_DREQ | E_DWE | E_BUSY | ((s == 7) ? E_BERR : 13'h0), s);
      add(1, 0, 7'd0, 0, 0, 1, 13'h0, s);
    end

    // 9: fetch timeout, then a fetch that completes and decodes as illegal
    for (int k = 1; k <= 15; k++) add(1, 1, 7'd0, 0, 0, 1, E_IMEM | E_BUSY, 9);
    add(1, 1, 7'd0, 0, 0, 1, E_IMEM | E_BERR | E_BUSY, 9);
    add(1, 1, 7'd0, 0, 0, 1, E_IMEM | E_BUSY, 9);
    add(1, 1, 7'd0, 0, 1, 0, E_FDONE, 9);
    add(1, 1, 7'h7F, 0, 0, 0, E_ILL | E_BUSY, 9);
    add(1, 0, 7'd0, 0, 0, 0, 13'h0, 9);

    // 10: reset during MEM of a load aborts it; no write-back follows
    add(1, 1, 7'd0, 0, 1, 0, E_FDONE, 10);
    add(1, 1, OPC_LD, 0, 0, 0, E_BUSY, 10);
    add(1, 1, 7'd0, 0, 0, 0, E_MUX | E_ALU | E_BUSY, 10);
    add(1, 1, 7'd0, 0, 0, 0, E_DREQ | E_BUSY, 10);
    add(0, 1, 7'd0, 0, 0, 1, 13'h0, 10);
    add(1, 0, 7'd0, 0, 0, 1, 13'h0, 10);
    add(1, 0, 7'd0, 0, 1, 1, 13'h0, 10);
    add(1, 1, 7'd0, 0, 0, 1, E_IMEM | E_BUSY, 10);
    add(1, 1, 7'd0, 0, 1, 1, E_FDONE, 10);
    add(1, 1, OPC_ST, 0, 0, 1, E_BUSY, 10);
    add(1, 1, 7'd0, 0, 0, 0, E_MUX | E_ALU | E_BUSY, 10);
    add(1, 1, 7'd0, 0, 0, 1, E_DREQ | E_DWE | E_BUSY, 10);
    add(1, 0, 7'd0, 0, 0, 0, 13'h0, 10);

    // 100: randomized instruction stream
    for (int n = 0; n < 250; n++) gen_random(100);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the single-ALU processor datapath. It fetches an instruction, decodes its opcode class, and sequences the shared ALU through one instruction at a time. It drives the ALU operand-B select (`MUXsel1`: 0 = register data `R2D2`, 1 = immediate `imm`), plus the IR/PC/register-file/memory enables. Memory accesses use a req/ready handshake with a timeout watchdog.

## Interface
- `MEM_TIMEOUT`, default 15: max cycles waiting for `imem_ready`/`dmem_ready` before abort; legal range 1–255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `run` input 1: 1 allows a new fetch to start; sampled only in FETCH.
- `opcode` input 7: IR[6:0], valid from DECODE onward.
- `branch_taken` input 1: ALU compare result, sampled in EXECUTE.
- `imem_ready` input 1: instruction memory data valid.
- `dmem_ready` input 1: data memory access complete.
- `imem_req` output 1: instruction fetch request.
- `ir_we` output 1: IR load strobe.
- `pc_we` output 1: PC write enable.
- `pc_sel` output 1: 0 = PC+4, 1 = branch target.
- `MUXsel1` output 1: operand-B select, 0 = `R2D2`, 1 = `imm`.
- `aluout_we` output 1: ALU result register load.
- `dmem_req` output 1: data memory request.
- `dmem_we` output 1: 1 = store, 0 = load (meaningful only with `dmem_req`).
- `reg_we` output 1: register file write enable.
- `wb_sel` output 1: 0 = ALU result, 1 = load data.
- `illegal_op` output 1: one-cycle pulse for an unknown opcode.
- `bus_err` output 1: one-cycle pulse when a memory wait times out.
- `busy` output 1: 1 in every state except FETCH-idle (FETCH with `run`=0).

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB.
- Opcode classes are latched into `op_q` in DECODE:
  - R = 0110011
  - I = 0010011
  - LD = 0000011
  - ST = 0100011
  - BR = 1100011
  - any other opcode is illegal.
- FETCH:
  - `imem_req` = `run`.
  - On `imem_ready` with `run`=1: assert `ir_we` and `pc_we` (`pc_sel`=0), then go to DECODE.
- DECODE:
  - Latch the class.
  - If illegal: pulse `illegal_op`, return to FETCH, no other side effects.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - `MUXsel1` = 1 for I/LD/ST, 0 for R/BR.
  - `aluout_we` = 1 for R/I/LD/ST.
  - BR: `pc_we` = `branch_taken` with `pc_sel` = 1, then go to FETCH.
  - R/I go to WB; LD/ST go to MEM.
- MEM:
  - `dmem_req` = 1; `dmem_we` = 1 for ST.
  - On `dmem_ready`: LD goes to WB, ST goes to FETCH.
- WB: `reg_we` = 1; `wb_sel` = 1 for LD, 0 otherwise; then go to FETCH.
- `MUXsel1` is 0 outside EXECUTE.
- All outputs are decoded combinationally from the state register and `op_q`; every output not named for a state is 0 in that state.
- Wait counter (8-bit):
  - Clears on entering FETCH or MEM.
  - Increments each cycle the awaited ready is low (in FETCH, only while `run`=1).
  - When it reaches `MEM_TIMEOUT` with ready still low: pulse `bus_err`, drop the request, go to FETCH. No `ir_we`/`pc_we`/`reg_we` is issued for the aborted instruction.
- A ready that arrives in the same cycle the count hits `MEM_TIMEOUT` wins: normal completion, no `bus_err`.
- `imem_ready`/`dmem_ready` are ignored in states that do not await them.

## Timing
- While `rst_n`=0 at a rising edge:
  - Next state is FETCH, `op_q` = 0, counter = 0.
  - All outputs are forced to 0 during any cycle with `rst_n`=0, including `imem_req`.
- A reset mid-instruction aborts it; no partial writes occur after the reset edge.
- Minimum latencies, counted from the FETCH cycle in which `imem_ready`=1:
  - BR: 3 cycles.
  - R/I: 4 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
  - Illegal: 2 cycles.
- Each extra low-ready cycle adds one cycle.
- `ir_we` and `pc_we` (PC+4) coincide in the single FETCH-complete cycle.
- The branch `pc_we` occurs only in EXECUTE.

## Test plan
- R-type, `imem_ready` high in the first FETCH cycle: `busy` high, then FETCH/DECODE/EXECUTE/WB over 4 cycles. `MUXsel1`=0 and `aluout_we`=1 in cycle 3; `reg_we`=1, `wb_sel`=0 in cycle 4.
- LD (0000011) with `dmem_ready` low for 3 MEM cycles: `MUXsel1`=1 in EXECUTE; `dmem_req`=1, `dmem_we`=0 for 4 cycles; then WB with `reg_we`=1, `wb_sel`=1; total 8 cycles.
- BR with `branch_taken`=1, then repeat with 0: `pc_we`=1, `pc_sel`=1 in EXECUTE; with 0, `pc_we` stays 0; next state FETCH after 3 cycles in both cases.
- Opcode 1111111: `illegal_op` is a single pulse in DECODE; `reg_we`, `dmem_req`, `aluout_we` never assert; FETCH follows.
- ST with `dmem_ready` held low, `MEM_TIMEOUT`=15:
  - `bus_err` pulses in the 16th MEM cycle and the FSM returns to FETCH.
  - Rerun with ready rising on the 16th MEM cycle: no `bus_err`, normal completion.
- `rst_n`=0 asserted during MEM of a load: all outputs are 0 that cycle; the FSM restarts in FETCH with `op_q`=0 and no `reg_we` ever asserted. `run`=0 holds FETCH with `busy`=0 and `imem_req`=0.
